// File: rtl/loctag_meas_sched_if.sv
// Conversion request/acknowledge link between the measurement scheduler (master)
// and the serial-ADC reader (slave).
interface loctag_meas_sched_if;
  logic        conv_req;
  logic        conv_ack;
  logic [11:0] conv_data;

  modport master (
    output conv_req,
    input  conv_ack,
    input  conv_data
  );

  modport slave (
    input  conv_req,
    output conv_ack,
    output conv_data
  );
endinterface

// File: rtl/loctag_meas_sched.sv
// LocTag measurement scheduler: trigger sync, detector power-up, ADC request burst and
// accumulation. Define LOCTAG_SCHED_TIMEOUT_EN to build the conv_ack timeout and err flag.
module loctag_meas_sched #(
  parameter int CLK_PER_US       = 50,
  parameter int TRIG_DELAY_IN_US = 2,
  parameter int SETTLE_CYCLES    = 25,
  parameter int NUM_SAMPLES      = 16,
  parameter int SAMPLE_GAP       = 50,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                trig,
  input  logic [1:0]          mode,
  input  logic [1:0]          mac_q,
  loctag_meas_sched_if.master conv,
  output logic                lt5534_en,
  output logic                ctrl_1,
  output logic [15:0]         sum,
  output logic                sum_valid,
  output logic                busy,
  output logic                err
);
  localparam int DELAY_CYCLES = TRIG_DELAY_IN_US * CLK_PER_US;
  localparam int MAX_A        = (DELAY_CYCLES > SETTLE_CYCLES) ? DELAY_CYCLES : SETTLE_CYCLES;
  localparam int MAX_B        = (SAMPLE_GAP > ACK_TIMEOUT) ? SAMPLE_GAP : ACK_TIMEOUT;
  localparam int CNT_MAX      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W        = $clog2(CNT_MAX + 1);
  localparam int SCNT_W       = $clog2(NUM_SAMPLES + 1);

  localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(SAMPLE_GAP - 1);
  localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_SETTLE, S_REQ, S_WAIT_ACK, S_GAP, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sync_reg;
  logic              trig_prev_reg;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SCNT_W-1:0] scnt_reg, scnt_next;
  logic [15:0]       acc_reg, acc_next;
  logic [15:0]       sum_reg, sum_next;
  logic              sum_valid_reg, sum_valid_next;
  logic              conv_req_reg, conv_req_next;
  logic              cont_reg, cont_next;
  logic              mac_nz_reg, mac_nz_next;
  logic              trig_s, trig_rise, aborting;

  assign trig_s    = sync_reg[1];
  assign trig_rise = trig_s & ~trig_prev_reg;
  // A dropped trigger abandons the measurement anywhere between acceptance and DONE.
  assign aborting  = ~trig_s && (state_reg inside {S_DELAY, S_SETTLE, S_REQ, S_WAIT_ACK, S_GAP});

`ifdef LOCTAG_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic err_reg, err_next;
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    scnt_next      = scnt_reg;
    acc_next       = acc_reg;
    sum_next       = sum_reg;
    sum_valid_next = 1'b0;
    conv_req_next  = 1'b0;
    cont_next      = cont_reg;
    mac_nz_next    = mac_nz_reg;
`ifdef LOCTAG_SCHED_TIMEOUT_EN
    err_next       = err_reg;
`endif
    if (aborting) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (trig_rise && (mode == 2'b01 || mode == 2'b10)) begin
            cont_next   = mode[1];
            mac_nz_next = |mac_q;
            acc_next    = '0;
            scnt_next   = '0;
            cnt_next    = '0;
`ifdef LOCTAG_SCHED_TIMEOUT_EN
            err_next    = 1'b0;
`endif
            state_next  = S_DELAY;
          end
        end
        S_DELAY: begin
          if (cnt_reg == DELAY_LAST) begin
            cnt_next   = '0;
            state_next = S_SETTLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_reg == SETTLE_LAST) begin
            cnt_next   = '0;
            state_next = S_REQ;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_REQ: begin
          conv_req_next = 1'b1;
          cnt_next      = '0;
          state_next    = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (conv.conv_ack) begin
            acc_next  = acc_reg + {4'd0, conv.conv_data};
            scnt_next = scnt_reg + 1'b1;
            cnt_next  = '0;
            if (scnt_reg == SAMPLE_LAST) begin
              sum_next       = acc_next;
              sum_valid_next = 1'b1;
              state_next     = S_DONE;
            end else begin
              state_next = S_GAP;
            end
`ifdef LOCTAG_SCHED_TIMEOUT_EN
          end else if (cnt_reg == TIMEOUT_LAST) begin
            err_next   = 1'b1;
            cnt_next   = '0;
            state_next = S_IDLE;
          end else begin
            cnt_next      = cnt_reg + 1'b1;
            conv_req_next = 1'b1;
          end
`else
          end else begin
            conv_req_next = 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next   = '0;
            state_next = S_REQ;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          // Continuous mode re-runs from SETTLE with the detector still powered.
          if (cont_reg && trig_s) begin
            acc_next   = '0;
            scnt_next  = '0;
            cnt_next   = '0;
            state_next = S_SETTLE;
          end else begin
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg      <= 2'b00;
      trig_prev_reg <= 1'b0;
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      scnt_reg      <= '0;
      acc_reg       <= '0;
      sum_reg       <= '0;
      sum_valid_reg <= 1'b0;
      conv_req_reg  <= 1'b0;
      cont_reg      <= 1'b0;
      mac_nz_reg    <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], trig};
      trig_prev_reg <= trig_s;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      scnt_reg      <= scnt_next;
      acc_reg       <= acc_next;
      sum_reg       <= sum_next;
      sum_valid_reg <= sum_valid_next;
      conv_req_reg  <= conv_req_next;
      cont_reg      <= cont_next;
      mac_nz_reg    <= mac_nz_next;
    end
  end

`ifdef LOCTAG_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_reg <= 1'b0;
    else        err_reg <= err_next;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign conv.conv_req = conv_req_reg;
  assign sum           = sum_reg;
  assign sum_valid     = sum_valid_reg;
  assign busy          = (state_reg != S_IDLE);
  assign lt5534_en     = (state_reg != S_IDLE);
  assign ctrl_1        = mac_nz_reg && (state_reg inside {S_SETTLE, S_REQ, S_WAIT_ACK, S_GAP, S_DONE});
endmodule

// File: tb/tb_loctag_meas_sched.sv
// Directed/randomized bench for loctag_meas_sched: a random-latency ADC responder records
// every sample it hands over, and expected sums/timings come from that record and the rules.
module tb_loctag_meas_sched;
  localparam int CLK_PER_US       = 50;
  localparam int TRIG_DELAY_IN_US = 2;
  localparam int SETTLE_CYCLES    = 25;
  localparam int NUM_SAMPLES      = 16;
  localparam int DELAY_CYCLES     = TRIG_DELAY_IN_US * CLK_PER_US;
  localparam int FIRST_REQ        = 3 + DELAY_CYCLES + SETTLE_CYCLES + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig;
  logic [1:0]  mode;
  logic [1:0]  mac_q;
  logic        lt5534_en, ctrl_1, sum_valid, busy, err;
  logic [15:0] sum;

  loctag_meas_sched_if tb_if ();

  loctag_meas_sched dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .mode      (mode),
    .mac_q     (mac_q),
    .conv      (tb_if),
    .lt5534_en (lt5534_en),
    .ctrl_1    (ctrl_1),
    .sum       (sum),
    .sum_valid (sum_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ADC responder state
  int          ack_q[$];
  logic        adc_en = 1'b1;
  logic        adc_fixed = 1'b0;
  int          adc_lat_min = 0;
  int          adc_lat_max = 6;

  // Monitor state
  int          sv_cnt = 0;
  int          req_rises = 0;
  int          en_falls = 0;
  int          ctrl_cnt = 0;
  logic [15:0] sums_q[$];
  logic        req_prev = 1'b0;
  logic        en_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_chunk(input int k);
    int s = 0;
    for (int i = 0; i < NUM_SAMPLES; i++) s += ack_q[k*NUM_SAMPLES + i];
    return s;
  endfunction

  initial begin
    int lat;
    logic [11:0] d;
    tb_if.conv_ack  = 1'b0;
    tb_if.conv_data = 12'd0;
    forever begin
      @(negedge clk);
      if (reset && adc_en && tb_if.conv_req && !tb_if.conv_ack) begin
        lat = $urandom_range(adc_lat_max, adc_lat_min);
        repeat (lat) @(negedge clk);
        if (reset && tb_if.conv_req) begin
          d = adc_fixed ? 12'hFFF : 12'($urandom_range(4095, 0));
          tb_if.conv_ack  = 1'b1;
          tb_if.conv_data = d;
          ack_q.push_back(int'(d));
          @(negedge clk);
          tb_if.conv_ack = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (tb_if.conv_req && !req_prev) req_rises++;
    req_prev = tb_if.conv_req;
    if (!lt5534_en && en_prev) en_falls++;
    en_prev = lt5534_en;
    if (ctrl_1) ctrl_cnt++;
    if (sum_valid) begin
      sv_cnt++;
      sums_q.push_back(sum);
    end
  end

  task automatic start_burst(input logic [1:0] m, input logic [1:0] q);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    mode  = m;
    mac_q = q;
    trig  = 1'b1;
  endtask

  task automatic wait_first_req(input string tag, input int start_cyc);
    int c = start_cyc;
    while (!tb_if.conv_req && c < 1000) begin @(negedge clk); c++; end
    check({tag, "_first_req"}, c, FIRST_REQ);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check({tag, "_idle"}, 32'(c < budget), 1);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_en"}, lt5534_en, 0);
    check({tag, "_req"}, tb_if.conv_req, 0);
    check({tag, "_ctrl"}, ctrl_1, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_sumv"}, sum_valid, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int c, n, rises, base_sv, base_q, base_en, base_req, base_ctrl, last_exp, active;
    logic rp, en2, en3, ctrl_d, ctrl_s0, ctrl_s1;
    logic [1:0] mq;
    reset = 1'b0; trig = 1'b0; mode = 2'b00; mac_q = 2'b00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single burst, random nonzero slot, random data/latency
    ack_q.delete();
    base_sv = sv_cnt; base_q = sums_q.size(); base_req = req_rises;
    mq = 2'($urandom_range(3, 1));
    start_burst(2'b01, mq);
    c = 0; en2 = 1'b1; en3 = 1'b0; ctrl_d = 1'b1; ctrl_s0 = 1'b1; ctrl_s1 = 1'b0;
    while (!tb_if.conv_req && c < 1000) begin
      @(negedge clk); c++;
      if (c == 2) en2 = lt5534_en;
      if (c == 3) en3 = lt5534_en;
      if (c == 50) ctrl_d = ctrl_1;
      if (c == 2 + DELAY_CYCLES) ctrl_s0 = ctrl_1;
      if (c == 3 + DELAY_CYCLES) ctrl_s1 = ctrl_1;
    end
    check("t1_first_req", c, FIRST_REQ);
    check("t1_en_before_accept", en2, 0);
    check("t1_en_after_accept", en3, 1);
    check("t1_ctrl_in_delay", ctrl_d, 0);
    check("t1_ctrl_last_delay", ctrl_s0, 0);
    check("t1_ctrl_first_settle", ctrl_s1, 1);
    check("t1_ctrl_at_req", ctrl_1, 1);
    wait_idle("t1", 5000);
    last_exp = exp_chunk(0);
    check("t1_acks", ack_q.size(), NUM_SAMPLES);
    check("t1_reqs", req_rises - base_req, NUM_SAMPLES);
    check("t1_sv_count", sv_cnt - base_sv, 1);
    check("t1_sum_pulse", sums_q[base_q], last_exp);
    check("t1_sum_hold", sum, last_exp);
    check("t1_err", err, 0);
    $display("burst single mac=%0d: sum=%0d expected=%0d", mq, sum, last_exp);

    // Continuous: three full-scale bursts, then trig released
    ack_q.delete(); adc_fixed = 1'b1;
    base_sv = sv_cnt; base_q = sums_q.size(); base_en = en_falls;
    start_burst(2'b10, 2'($urandom_range(3, 1)));
    n = 0; c = 0;
    while (n < 3 && c < 20000) begin
      @(negedge clk); c++;
      if (sum_valid) n++;
    end
    trig = 1'b0;
    check("t2_bursts_seen", n, 3);
    wait_idle("t2", 200);
    check("t2_sv_count", sv_cnt - base_sv, 3);
    check("t2_acks", ack_q.size(), 3 * NUM_SAMPLES);
    for (int k = 0; k < 3; k++) begin
      check("t2_sum", sums_q[base_q + k], exp_chunk(k));
      $display("burst continuous %0d: sum=%0d expected=%0d", k, sums_q[base_q + k], exp_chunk(k));
    end
    check("t2_en_falls", en_falls - base_en, 1);
    last_exp = exp_chunk(2);
    adc_fixed = 1'b0;

    // Abort during the 5th WAIT_ACK
    ack_q.delete(); adc_lat_min = 8; adc_lat_max = 10;
    base_sv = sv_cnt;
    start_burst(2'b01, 2'b01);
    rises = 0; rp = 1'b0; c = 0;
    while (rises < 5 && c < 3000) begin
      @(negedge clk); c++;
      if (tb_if.conv_req && !rp) rises++;
      rp = tb_if.conv_req;
    end
    check("t3_reached_5th", rises, 5);
    trig = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_req_dropped", tb_if.conv_req, 0);
    check("t3_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("t3_no_sv", sv_cnt - base_sv, 0);
    check("t3_sum_held", sum, last_exp);
    $display("burst aborted: sum=%0d expected=%0d", sum, last_exp);
    adc_lat_min = 0; adc_lat_max = 6;

    // Modes 00 and 11 ignore the trigger
    for (int m = 0; m < 4; m += 3) begin
      start_burst(2'(m), 2'b11);
      active = 0;
      repeat (200) begin
        @(negedge clk);
        if (busy || lt5534_en || tb_if.conv_req || ctrl_1) active++;
      end
      check("t4_mode_off_quiet", active, 0);
    end

    // mac_q = 0 burst: ctrl_1 never rises
    ack_q.delete(); base_ctrl = ctrl_cnt; base_sv = sv_cnt;
    start_burst(2'b01, 2'b00);
    wait_first_req("t5", 0);
    wait_idle("t5", 5000);
    last_exp = exp_chunk(0);
    check("t5_ctrl_quiet", ctrl_cnt - base_ctrl, 0);
    check("t5_sv_count", sv_cnt - base_sv, 1);
    check("t5_sum", sum, last_exp);
    $display("burst mac=0: sum=%0d expected=%0d", sum, last_exp);

`ifdef LOCTAG_SCHED_TIMEOUT_EN
    // No ack: err after the timeout, then cleared by the next accepted trigger
    adc_en = 1'b0; ack_q.delete();
    start_burst(2'b01, 2'b01);
    wait_first_req("t6", 0);
    c = 0;
    while (!err && c < 1000) begin @(negedge clk); c++; end
    check("t6_err_latency", c, 255);
    check("t6_busy", busy, 0);
    check("t6_req", tb_if.conv_req, 0);
    adc_en = 1'b1;
    start_burst(2'b01, 2'b01);
    repeat (2) @(negedge clk);
    check("t6_err_sticky", err, 1);
    @(negedge clk);
    check("t6_err_cleared", err, 0);
    wait_first_req("t6b", 3);
    wait_idle("t6", 5000);
    last_exp = exp_chunk(0);
    check("t6_sum", sum, last_exp);
    $display("burst after timeout: sum=%0d expected=%0d", sum, last_exp);
`endif

    // Asynchronous reset in the middle of a GAP
    ack_q.delete();
    start_burst(2'b01, 2'b10);
    rises = 0; rp = 1'b0; c = 0;
    while (!(rises == 3 && !tb_if.conv_req) && c < 3000) begin
      @(negedge clk); c++;
      if (tb_if.conv_req && !rp) rises++;
      rp = tb_if.conv_req;
    end
    check("t7_reached_gap", rises, 3);
    repeat (10) @(negedge clk);
    #3 reset = 1'b0;
    #1 check_all_zero("t7_async");
    trig = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    ack_q.delete(); base_sv = sv_cnt;
    start_burst(2'b01, 2'b10);
    wait_first_req("t7", 0);
    wait_idle("t7", 5000);
    last_exp = exp_chunk(0);
    check("t7_sv_count", sv_cnt - base_sv, 1);
    check("t7_acks", ack_q.size(), NUM_SAMPLES);
    check("t7_sum", sum, last_exp);
    $display("burst after reset: sum=%0d expected=%0d", sum, last_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
